load_store_unit: RTL and testbench

- Memory-access stage directly downstream of the instruction decoder; consumes its address-valid, write-enable, address, byte-mask and sign-extend controls plus the rs2 store data.
- Converts each request into one word-aligned bus transaction with byte lanes, and returns a lane-aligned, zero- or sign-extended load result for the register-file write port.
- Stalls the core via busy_o until the access completes, faults or times out.

---
 rtl/load_store_unit.sv | 144 ++++++++++++++
 tb/tb_load_store_unit.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: turns one decoded memory access into a single word-aligned
// bus transaction and returns a lane-aligned, extended load result.
module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic        clk,
  input  logic        reset_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [3:0]  mask_i,
  input  logic        sext_i,
  input  logic [31:0] wdata_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [1:0]  err_o,
  output logic [31:0] rdata_o,
  output logic        mem_valid_o,
  input  logic        mem_ready_i,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [3:0]  mem_wmask_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i
);

  typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state;
  logic             we_q;
  logic [1:0]       off_q;
  logic [3:0]       mask_q;
  logic             sext_q;
  logic             fault_q;
  logic [CNT_W-1:0] cnt;

  logic             misaligned;
  logic [31:0]      shifted;
  logic [31:0]      ld_data;

  // alignment check on the incoming request
  always_comb begin
    misaligned = 1'b1;
    case (mask_i)
      4'b0001: misaligned = 1'b0;
      4'b0011: misaligned = addr_i[0];
      4'b1111: misaligned = |addr_i[1:0];
      default: misaligned = 1'b1;
    endcase
  end

  // lane-align the read word and extend to 32 bits
  always_comb begin
    shifted = mem_rdata_i >> {off_q, 3'b000};
    case (mask_q)
      4'b0001: ld_data = {{24{sext_q & shifted[7]}},
                          shifted[7:0]};
      4'b0011: ld_data = {{16{sext_q & shifted[15]}},
                          shifted[15:0]};
      default: ld_data = shifted;
    endcase
  end

  // control FSM with registered outputs; a misaligned request
  // spends its first busy cycle in BUS without a bus request so
  // that it completes with the same latency as a zero-wait access
  always_ff @(posedge clk) begin
    if (reset_i) begin
      state       <= IDLE;
      we_q        <= 1'b0;
      off_q       <= 2'b00;
      mask_q      <= 4'b0000;
      sext_q      <= 1'b0;
      fault_q     <= 1'b0;
      cnt         <= '0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      err_o       <= 2'b00;
      rdata_o     <= '0;
      mem_valid_o <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wmask_o <= '0;
      mem_wdata_o <= '0;
    end else begin
      done_o <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req_i) begin
            we_q    <= we_i;
            off_q   <= addr_i[1:0];
            mask_q  <= mask_i;
            sext_q  <= sext_i;
            fault_q <= misaligned;
            busy_o  <= 1'b1;
            state   <= BUS;
            if (!misaligned) begin
              mem_valid_o <= 1'b1;
              mem_we_o    <= we_i;
              mem_addr_o  <= {addr_i[31:2], 2'b00};
              mem_wmask_o <= 4'(mask_i << addr_i[1:0]);
              mem_wdata_o <= wdata_i << {addr_i[1:0], 3'b000};
            end
          end
        end
        BUS: begin
          if (fault_q) begin
            err_o  <= 2'b01;
            done_o <= 1'b1;
            busy_o <= 1'b0;
            state  <= DONE;
          end else if (mem_ready_i) begin
            if (!we_q) rdata_o <= ld_data;
            err_o       <= 2'b00;
            done_o      <= 1'b1;
            busy_o      <= 1'b0;
            mem_valid_o <= 1'b0;
            state       <= DONE;
          end else if (TIMEOUT_CYCLES != 0 &&
                       cnt == CNT_LAST) begin
            err_o       <= 2'b10;
            done_o      <= 1'b1;
            busy_o      <= 1'b0;
            mem_valid_o <= 1'b0;
            state       <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          cnt     <= '0;
          fault_q <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed test-plan steps plus random
// accesses checked against a byte-level reference model.
module tb_load_store_unit;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset_i;
  logic        req_i;
  logic        we_i;
  logic [31:0] addr_i;
  logic [3:0]  mask_i;
  logic        sext_i;
  logic [31:0] wdata_i;
  logic        busy_o;
  logic        done_o;
  logic [1:0]  err_o;
  logic [31:0] rdata_o;
  logic        mem_valid_o;
  logic        mem_ready_i;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [3:0]  mem_wmask_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i;

  int passed = 0;
  int total  = 0;
  int fails  = 0;
  logic [31:0] model_rd = '0;

  always #5 clk = ~clk;

  load_store_unit #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
    .clk         (clk),
    .reset_i     (reset_i),
    .req_i       (req_i),
    .we_i        (we_i),
    .addr_i      (addr_i),
    .mask_i      (mask_i),
    .sext_i      (sext_i),
    .wdata_i     (wdata_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .err_o       (err_o),
    .rdata_o     (rdata_o),
    .mem_valid_o (mem_valid_o),
    .mem_ready_i (mem_ready_i),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wmask_o (mem_wmask_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_rdata_i (mem_rdata_i)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // delay = idle bus cycles before ready; delay >= TO never readies
  task automatic txn(input logic we, input logic [31:0] addr,
                     input logic [3:0] mask, input logic sext,
                     input logic [31:0] wd, input logic [31:0] rd,
                     input int delay);
    int sz, off, cyc, ecyc;
    bit bad;
    logic [3:0]  ewm;
    logic [31:0] ewd;
    logic [1:0]  eerr;
    longint v;
    off = int'(addr[1:0]);
    sz = (mask == 4'b0001) ? 1 : (mask == 4'b0011) ? 2 :
         (mask == 4'b1111) ? 4 : 0;
    bad = (sz == 0) ? 1'b1 : ((off % sz) != 0);
    ewm = 4'(((1 << sz) - 1) << off);
    ewd = 32'(longint'(wd) << (8 * off));
    @(negedge clk);
    req_i = 1'b1; we_i = we; addr_i = addr;
    mask_i = mask; sext_i = sext; wdata_i = wd;
    @(negedge clk);
    req_i = 1'b0; addr_i = $urandom; wdata_i = $urandom;
    if (bad) begin
      chk("mis_valid", mem_valid_o, 0);
      chk("mis_busy", busy_o, 1);
      chk("mis_done_early", done_o, 0);
      @(negedge clk);
      eerr = 2'b01;
    end else begin
      cyc = 0;
      while (done_o !== 1'b1 && cyc < 12) begin
        chk("valid", mem_valid_o, 1);
        chk("busy", busy_o, 1);
        chk("addr", mem_addr_o, {addr[31:2], 2'b00});
        chk("wmask", mem_wmask_o, ewm);
        chk("we", mem_we_o, we);
        if (we) chk("wdata", mem_wdata_o, ewd);
        if (cyc == delay) begin
          mem_ready_i = 1'b1; mem_rdata_i = rd;
        end
        @(negedge clk);
        mem_ready_i = 1'b0; mem_rdata_i = $urandom;
        cyc++;
      end
      if (delay < TO) begin
        eerr = 2'b00; ecyc = delay + 1;
        if (!we) begin
          v = (longint'(rd) >> (8 * off)) %
              (longint'(1) << (8 * sz));
          if (sext && sz < 4 &&
              v >= (longint'(1) << (8 * sz - 1)))
            v = v - (longint'(1) << (8 * sz));
          model_rd = 32'(v);
        end
      end else begin
        eerr = 2'b10; ecyc = TO;
      end
      chk("bus_cycles", cyc, ecyc);
    end
    chk("done", done_o, 1);
    chk("err", err_o, eerr);
    chk("busy_done", busy_o, 0);
    chk("valid_done", mem_valid_o, 0);
    chk("rdata", rdata_o, model_rd);
    @(negedge clk);
    chk("done_pulse", done_o, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_i = 1'b1; req_i = 1'b0; we_i = 1'b0; addr_i = '0;
    mask_i = '0; sext_i = 1'b0; wdata_i = '0;
    mem_ready_i = 1'b0; mem_rdata_i = '0;
    repeat (2) @(negedge clk);
    reset_i = 1'b0;
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_rdata", rdata_o, 0);
    chk("rst_valid", mem_valid_o, 0);
    chk("rst_we", mem_we_o, 0);
    chk("rst_addr", mem_addr_o, 0);
    chk("rst_wmask", mem_wmask_o, 0);
    chk("rst_wdata", mem_wdata_o, 0);

    txn(0, 32'h1000, 4'b1111, 0, 0, 32'hDEADBEEF, 3);
    chk("lw_const", rdata_o, 32'hDEADBEEF);
    txn(0, 32'h2003, 4'b0001, 1, 0, 32'h80AABBCC, 0);
    chk("lb_const", rdata_o, 32'hFFFFFF80);
    txn(0, 32'h2003, 4'b0001, 0, 0, 32'h80AABBCC, 0);
    chk("lbu_const", rdata_o, 32'h00000080);
    txn(1, 32'h3002, 4'b0011, 0, 32'h0000ABCD, 0, 1);
    chk("sh_keeps_rdata", rdata_o, 32'h00000080);
    txn(1, 32'h4001, 4'b1111, 0, 32'h12345678, 0, 0);
    chk("sw_mis_err", err_o, 2'b01);
    txn(0, 32'h4003, 4'b0011, 1, 0, 0, 0);
    txn(0, 32'h5000, 4'b1111, 0, 0, 32'h11112222, 100);
    txn(0, 32'h5004, 4'b1111, 0, 0, 32'h33334444, TO - 1);
    txn(0, 32'h6002, 4'b0011, 1, 0, 32'h9ABC0000, 0);
    chk("lh_const", rdata_o, 32'hFFFF9ABC);

    // reset while waiting on the bus
    @(negedge clk);
    req_i = 1'b1; we_i = 1'b0; addr_i = 32'h7000;
    mask_i = 4'b1111; sext_i = 1'b0;
    @(negedge clk);
    req_i = 1'b0;
    chk("pre_rst_valid", mem_valid_o, 1);
    @(negedge clk);
    reset_i = 1'b1;
    @(negedge clk);
    reset_i = 1'b0;
    model_rd = '0;
    chk("abort_valid", mem_valid_o, 0);
    chk("abort_busy", busy_o, 0);
    chk("abort_done", done_o, 0);
    mem_ready_i = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("abort_no_done", done_o, 0);
      chk("idle_ready_ignored", busy_o, 0);
    end
    mem_ready_i = 1'b0;
    txn(0, 32'h7000, 4'b1111, 0, 0, 32'hCAFEF00D, 0);

    for (int i = 0; i < 40; i++) begin
      logic [3:0] m;
      int pick;
      pick = $urandom_range(0, 9);
      m = (pick < 3) ? 4'b0001 : (pick < 6) ? 4'b0011 :
          (pick < 9) ? 4'b1111 : 4'($urandom);
      txn(1'($urandom), $urandom, m, 1'($urandom), $urandom,
          $urandom, $urandom_range(0, 5));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
